// File: rtl/icache_pkg.sv
// Shared constants and FSM encoding for the direct-mapped instruction cache.
package icache_pkg;

  localparam int unsigned NUM_SETS    = 8;
  localparam int unsigned BLOCK_WORDS = 4;
  localparam int unsigned TAG_W       = 25;
  localparam int unsigned LINE_W      = 32 * BLOCK_WORDS;

  localparam int unsigned OFFSET_LSB = 2;
  localparam int unsigned INDEX_LSB  = 4;
  localparam int unsigned TAG_LSB    = 7;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StMemRead = 2'd1,
    StUpdate  = 2'd2
  } icache_state_e;

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays for the instruction cache: one combinational read port, one write port.
module icache_line_store
  import icache_pkg::*;
#(
  parameter int unsigned NumSets = NUM_SETS,
  parameter int unsigned TagW    = TAG_W,
  localparam int unsigned IdxW   = $clog2(NumSets)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IdxW-1:0]   rd_index,
  output logic              rd_valid,
  output logic [TagW-1:0]   rd_tag,
  output logic [LINE_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IdxW-1:0]   wr_index,
  input  logic [TagW-1:0]   wr_tag,
  input  logic [LINE_W-1:0] wr_data
);

  logic [NumSets-1:0] valid_q;
  logic [TagW-1:0]    tag_q  [NumSets];
  logic [LINE_W-1:0]  data_q [NumSets];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tags and data are left uninitialised; a clear valid bit masks them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/instruction_cache_controller.sv
// Direct-mapped read-only instruction cache; fills whole 128-bit blocks from main memory on a miss.
module instruction_cache_controller
  import icache_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       address,
  output logic [31:0]       instruction,
  output logic              busywait,
  output logic              mem_read,
  output logic [27:0]       mem_address,
  input  logic [LINE_W-1:0] mem_readdata,
  input  logic              mem_busywait
);

  localparam int unsigned IdxW = $clog2(NUM_SETS);

  icache_state_e state_q, state_d;
  logic [27:0]   miss_addr_q, miss_addr_d;

  logic [IdxW-1:0]   index;
  logic [TAG_W-1:0]  tag;
  logic [1:0]        offset;
  logic              unused_byte_bits;
  logic              line_valid;
  logic [TAG_W-1:0]  line_tag;
  logic [LINE_W-1:0] line_data;
  logic              hit;
  logic              fill;
  logic              fsm_busy;

  assign index            = address[INDEX_LSB +: IdxW];
  assign tag              = address[TAG_LSB +: TAG_W];
  assign offset           = address[OFFSET_LSB +: 2];
  assign unused_byte_bits = ^address[1:0];

  icache_line_store #(
    .NumSets (NUM_SETS),
    .TagW    (TAG_W)
  ) u_line_store (
    .clk      (clk),
    .rst_n    (reset),
    .rd_index (index),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (fill),
    .wr_index (miss_addr_q[IdxW-1:0]),
    .wr_tag   (miss_addr_q[IdxW +: TAG_W]),
    .wr_data  (mem_readdata)
  );

  assign hit         = line_valid && (line_tag == tag);
  assign instruction = line_data[32 * offset +: 32];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    fsm_busy    = 1'b1;
    mem_read    = 1'b0;
    fill        = 1'b0;
    unique case (state_q)
      StIdle: begin
        fsm_busy = ~hit;
        if (!hit) begin
          state_d     = StMemRead;
          miss_addr_d = address[31:4];
        end
      end
      StMemRead: begin
        mem_read = 1'b1;
        if (!mem_busywait) begin
          fill    = 1'b1;
          state_d = StUpdate;
        end
      end
      StUpdate: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  assign mem_address = miss_addr_q;
  // Never stall the upstream reset logic.
  assign busywait    = reset & fsm_busy;

endmodule

// File: doc/instruction_cache_controller.md
Name: instruction_cache_controller

Overview:
- Responder side of the instruction-fetch interface. Accepts the fetch stage's PC as a read address and returns the 32-bit instruction.
- Asserts busywait while servicing a miss, which stalls PC update upstream.
- Direct-mapped, read-only cache between the fetch stage and a block-wide instruction main memory.
- Fills whole blocks from main memory on a miss.

Parameters:
- NUM_SETS, 8, number of cache lines; power of two.
- BLOCK_WORDS, 4, 32-bit words per line; fixed, so main-memory data is 128 bits.
- TAG_W, 25, tag bits = 32 - 2 (byte) - 2 (word offset) - log2(NUM_SETS).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- address  in  32  fetch PC; word-aligned; held stable by the fetch stage while busywait=1.
- instruction  out  32  instruction word at address; valid when busywait=0.
- busywait  out  1  1 = instruction not yet available; the fetch stage must hold PC.
- mem_read  out  1  block read request to main memory.
- mem_address  out  28  block address = address[31:4].
- mem_readdata  in  128  block data; word k in bits [32k+31:32k].
- mem_busywait  in  1  1 = main memory still servicing mem_read.

Behaviour:
Address split:
- index = address[6:4]
- offset = address[3:2]
- tag = address[31:7]
- address[1:0] ignored.

Storage:
- Per line: valid bit, TAG_W tag, 128-bit data.
- Line registers written only on a fill edge.

Hit path:
- Combinational: hit = valid[index] & (tag_array[index] == tag).
- instruction = data_array[index] word[offset] regardless of hit. Value is meaningless when busywait=1.

FSM states: IDLE, MEM_READ, UPDATE.
- IDLE:
  - busywait = ~hit, mem_read = 0.
  - On miss, next state is MEM_READ.
- MEM_READ:
  - busywait = 1, mem_read = 1, mem_address = miss block address.
  - The miss block address is latched on the IDLE->MEM_READ edge.
  - Stay while mem_busywait = 1.
  - On the first rising edge with mem_busywait = 0:
    - write mem_readdata to data_array[index];
    - set tag_array[index] = latched tag;
    - set valid[index] = 1;
    - go to UPDATE.
- UPDATE:
  - busywait = 1, mem_read = 0.
  - Unconditionally return to IDLE next edge.
  - In IDLE the now-valid line hits, so busywait falls combinationally.

Latency:
- Hit: 0 cycles (same cycle).
- Miss: 1 cycle (IDLE decision) + memory latency cycles in MEM_READ + 1 UPDATE cycle.
- Minimum miss penalty: 3 cycles with zero-latency memory.

Reset (reset = 0, asynchronous):
- State = IDLE.
- All valid bits = 0.
- Latched miss address = 0.
- mem_read = 0.
- busywait forced to 0 while reset is asserted, so upstream reset logic is never stalled.
- Tag and data arrays are not cleared.

Boundary conditions:
- Reset mid-miss: the fill is abandoned, mem_read drops immediately, and no line is written.
- Address change while busywait = 1: a protocol violation. The fill still targets the latched address.
- Conflict miss: same index, different tag. The resident line is overwritten with no write-back (read-only cache).
- mem_busywait already 0 on the first MEM_READ cycle: fill occurs on that edge.
- Address 0xFFFFFFFC, the PC value held under reset: treated as an ordinary address (index 7, offset 3) if presented after reset releases.

Decomposition:
- Shared package icache_pkg:
  - FSM state encoding (IDLE = 2'd0, MEM_READ = 2'd1, UPDATE = 2'd2);
  - field position constants (OFFSET_LSB = 2, INDEX_LSB = 4, TAG_LSB = 7);
  - NUM_SETS and TAG_W defaults.
- One natural sub-module, icache_line_store: the valid/tag/data arrays with a combinational read port, one write port and async clear of valid bits.
- The FSM stays in instruction_cache_controller.

Test Plan:
- Reset: hold reset = 0 for 3 cycles with address = 0xFFFFFFFC -> busywait = 0, mem_read = 0 throughout; after release, all lines invalid.
- Cold miss, fill and hit:
  - Stimulus: address = 0x00000000; memory latency 5 cycles returns 0x0000000F_0000000E_0000000D_0000000C.
  - Expected during miss: busywait = 1 at once; mem_read = 1 with mem_address = 0x0000000 for 5 cycles.
  - Expected after fill: one UPDATE cycle, then instruction = 0x0000000C, busywait = 0.
- Spatial hits: following the fill, address 0x4, 0x8, 0xC on consecutive cycles -> busywait = 0, instruction = 0x0000000D, 0x0000000E, 0x0000000F, and no mem_read.
- Conflict miss: address = 0x00000080 (index 0, tag 1) -> mem_read with mem_address = 0x0000008; after fill, address 0x0 misses again.
- Reset mid-miss: assert reset on the 2nd MEM_READ cycle of a miss to 0x10 -> mem_read = 0 and busywait = 0 immediately; after release, 0x10 misses again and 0x0 also misses (valid cleared).
- Zero-latency memory: mem_busywait tied to 0, miss at 0x20 -> busywait high for exactly 3 cycles, then instruction = word 0 of the returned block.
